// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multiport integer register file.
package regfile_pkg;

  localparam int unsigned DEF_REGISTER_WIDTH   = 64;
  localparam int unsigned DEF_REGISTERNO_WIDTH = 5;
  localparam int unsigned DEF_NUM_REGS         = 32;
  localparam int unsigned DEF_NUM_READ_PORTS   = 2;
  localparam int unsigned DEF_NUM_WRITE_PORTS  = 2;

  typedef logic [DEF_REGISTERNO_WIDTH-1:0] regno_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Serial register-dump sequencer: walks register indices under a valid/ready
// handshake and pulses done once after the final beat.
module regfile_dump_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned REGISTERNO_WIDTH = DEF_REGISTERNO_WIDTH,
  parameter int unsigned NUM_REGS         = DEF_NUM_REGS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        dump_req,
  input  logic                        dump_ready,
  output logic                        dump_valid,
  output logic                        dump_done,
  output logic [REGISTERNO_WIDTH-1:0] dump_idx
);

  localparam logic [REGISTERNO_WIDTH-1:0] LAST_IDX = REGISTERNO_WIDTH'(NUM_REGS - 1);

  dump_state_e                 state_q;
  dump_state_e                 state_d;
  logic [REGISTERNO_WIDTH-1:0] idx_d;

  // Valid/done are registered decodes of the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      dump_idx   <= '0;
      dump_valid <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dump_idx   <= idx_d;
      dump_valid <= (state_d == ST_DUMP);
      dump_done  <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = dump_idx;
    case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          state_d = ST_DUMP;
          idx_d   = '0;
        end
      end
      ST_DUMP: begin
        if (dump_valid && dump_ready) begin
          if (dump_idx == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = dump_idx + REGISTERNO_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/multiport_register_file.sv
// Multiport integer register file with same-cycle write bypass, pending-write
// scoreboard and a handshaked serial dump port.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH   = DEF_REGISTER_WIDTH,
  parameter int unsigned REGISTERNO_WIDTH = DEF_REGISTERNO_WIDTH,
  parameter int unsigned NUM_REGS         = DEF_NUM_REGS,
  parameter int unsigned NUM_READ_PORTS   = DEF_NUM_READ_PORTS,
  parameter int unsigned NUM_WRITE_PORTS  = DEF_NUM_WRITE_PORTS,
  parameter bit          ZERO_REG         = 1'b1
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [NUM_READ_PORTS-1:0][REGISTERNO_WIDTH-1:0]  in_rs_regno,
  output logic [NUM_READ_PORTS-1:0][REGISTER_WIDTH-1:0]    nstage_rs_content,
  input  logic [NUM_WRITE_PORTS-1:0]                       in_wr_enable,
  input  logic [NUM_WRITE_PORTS-1:0][REGISTERNO_WIDTH-1:0] in_rd_regno,
  input  logic [NUM_WRITE_PORTS-1:0][REGISTER_WIDTH-1:0]   in_rd_value,
  input  logic                                             in_issue_valid,
  input  logic [REGISTERNO_WIDTH-1:0]                      in_issue_regno,
  output logic [NUM_REGS-1:0]                              out_busy,
  input  logic                                             in_dump_req,
  output logic                                             out_dump_valid,
  input  logic                                             in_dump_ready,
  output logic [REGISTERNO_WIDTH-1:0]                      out_dump_regno,
  output logic [REGISTER_WIDTH-1:0]                        out_dump_value,
  output logic                                             out_dump_done
);

  logic [REGISTER_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]       busy_d;

  // Ports applied in ascending order so the highest enabled port wins a collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (in_wr_enable[w] && !(ZERO_REG && (in_rd_regno[w] == '0))) begin
          regs_q[in_rd_regno[w]] <= in_rd_value[w];
        end
      end
    end
  end

  // Read with writeback bypass; the zero register overrides everything.
  always_comb begin
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      nstage_rs_content[p] = regs_q[in_rs_regno[p]];
      for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
        if (in_wr_enable[w] && (in_rd_regno[w] == in_rs_regno[p])) begin
          nstage_rs_content[p] = in_rd_value[w];
        end
      end
      if (ZERO_REG && (in_rs_regno[p] == '0)) begin
        nstage_rs_content[p] = '0;
      end
    end
  end

  // Writeback clears first so a same-cycle issue keeps the register pending.
  always_comb begin
    busy_d = out_busy;
    for (int w = 0; w < NUM_WRITE_PORTS; w++) begin
      if (in_wr_enable[w]) begin
        busy_d[in_rd_regno[w]] = 1'b0;
      end
    end
    if (in_issue_valid) begin
      busy_d[in_issue_regno] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_busy <= '0;
    end else begin
      out_busy <= busy_d;
    end
  end

  regfile_dump_ctrl #(
    .REGISTERNO_WIDTH (REGISTERNO_WIDTH),
    .NUM_REGS         (NUM_REGS)
  ) u_dump_ctrl (
    .clk        (clk),
    .reset      (reset),
    .dump_req   (in_dump_req),
    .dump_ready (in_dump_ready),
    .dump_valid (out_dump_valid),
    .dump_done  (out_dump_done),
    .dump_idx   (out_dump_regno)
  );

  // Dump shows committed contents only; no bypass.
  assign out_dump_value = regs_q[out_dump_regno];

endmodule
